add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_if.sv | 53 +++++
 rtl/add_arbiter.sv | 132 +++++++++++++
 tb/tb_add_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_arbiter_if.sv
// Requester, result and shared-adder bundle for add_arbiter.
// ovf_cnt exists only when ADD_ARBITER_OVF_CNT_EN is defined.
interface add_arbiter_if;
   logic        req0;
   logic        req1;
   logic [31:0] a0;
   logic [31:0] b0;
   logic [31:0] a1;
   logic [31:0] b1;
   logic        sub0;
   logic        sub1;
   logic        ack0;
   logic        ack1;
   logic [31:0] result;
   logic        ovf;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_cin;
   logic [31:0] add_sum;
   logic        add_ovf;
   logic        busy;
`ifdef ADD_ARBITER_OVF_CNT_EN
   logic [7:0]  ovf_cnt;
`endif

   modport slave (
      input  req0, req1,
      input  a0, b0, a1, b1,
      input  sub0, sub1,
      input  add_sum, add_ovf,
      output ack0, ack1,
      output result, ovf,
      output add_a, add_b, add_cin,
`ifdef ADD_ARBITER_OVF_CNT_EN
      output ovf_cnt,
`endif
      output busy
   );

   modport master (
      output req0, req1,
      output a0, b0, a1, b1,
      output sub0, sub1,
      output add_sum, add_ovf,
      input  ack0, ack1,
      input  result, ovf,
      input  add_a, add_b, add_cin,
`ifdef ADD_ARBITER_OVF_CNT_EN
      input  ovf_cnt,
`endif
      input  busy
   );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one external adder between two requesters.
// Define ADD_ARBITER_OVF_CNT_EN to add the saturating ovf_cnt output.
module add_arbiter (
   input logic        clock,
   input logic        reset_n,
   add_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DONE
   } state_e;

   state_e      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        gnt_q, gnt_d;
   logic [31:0] add_a_q, add_a_d;
   logic [31:0] add_b_q, add_b_d;
   logic        add_cin_q, add_cin_d;
   logic [31:0] result_q, result_d;
   logic        ovf_q, ovf_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        busy_q, busy_d;
`ifdef ADD_ARBITER_OVF_CNT_EN
   logic [7:0]  ovf_cnt_q, ovf_cnt_d;
`endif

   logic        pick;
   logic        sel_sub;
   logic [31:0] sel_b;

   always_comb begin
      // Pointer only breaks ties; a lone request always wins.
      pick = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
      sel_sub   = pick ? bus.sub1 : bus.sub0;
      sel_b     = pick ? bus.b1 : bus.b0;
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      add_a_d   = add_a_q;
      add_b_d   = add_b_q;
      add_cin_d = add_cin_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      ack0_d    = ack0_q;
      ack1_d    = ack1_q;
      busy_d    = busy_q;
`ifdef ADD_ARBITER_OVF_CNT_EN
      ovf_cnt_d = ovf_cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               state_d   = ISSUE;
               gnt_d     = pick;
               ptr_d     = ~pick;
               add_a_d   = pick ? bus.a1 : bus.a0;
               add_b_d   = sel_sub ? ~sel_b : sel_b;
               add_cin_d = sel_sub;
               busy_d    = 1'b1;
            end
         end
         ISSUE: begin
            state_d  = DONE;
            result_d = bus.add_sum;
            ovf_d    = bus.add_ovf;
            ack0_d   = ~gnt_q;
            ack1_d   = gnt_q;
         end
         DONE: begin
            state_d = IDLE;
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            busy_d  = 1'b0;
`ifdef ADD_ARBITER_OVF_CNT_EN
            if (ovf_q && ovf_cnt_q != 8'hFF)
               ovf_cnt_d = ovf_cnt_q + 8'd1;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ptr_q     <= 1'b0;
         gnt_q     <= 1'b0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         add_cin_q <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef ADD_ARBITER_OVF_CNT_EN
         ovf_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         add_cin_q <= add_cin_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         busy_q    <= busy_d;
`ifdef ADD_ARBITER_OVF_CNT_EN
         ovf_cnt_q <= ovf_cnt_d;
`endif
      end
   end

   assign bus.add_a   = add_a_q;
   assign bus.add_b   = add_b_q;
   assign bus.add_cin = add_cin_q;
   assign bus.result  = result_q;
   assign bus.ovf     = ovf_q;
   assign bus.ack0    = ack0_q;
   assign bus.ack1    = ack1_q;
   assign bus.busy    = busy_q;
`ifdef ADD_ARBITER_OVF_CNT_EN
   assign bus.ovf_cnt = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter with a behavioural shared adder.
// Saturation checks run only when ADD_ARBITER_OVF_CNT_EN is defined.
module tb_add_arbiter;
   logic clock;
   logic reset_n;
   int   total;
   int   bad;

   typedef struct {
      logic        idx;
      logic [31:0] res;
      logic        ovf;
   } sb_t;

   sb_t q[$];

   add_arbiter_if bus ();

   add_arbiter dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign bus.add_sum = bus.add_a + bus.add_b
                      + {31'b0, bus.add_cin};
   assign bus.add_ovf = (bus.add_a[31] == bus.add_b[31])
                     && (bus.add_sum[31] != bus.add_a[31]);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void push(input logic idx,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                input logic s);
      sb_t e;
      e.idx = idx;
      e.res = s ? a - b : a + b;
      if (s)
         e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]);
      else
         e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]);
      q.push_back(e);
   endfunction

   task automatic drive(input logic idx, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
      if (idx) begin
         bus.a1 = a; bus.b1 = b; bus.sub1 = s; bus.req1 = 1'b1;
      end else begin
         bus.a0 = a; bus.b0 = b; bus.sub0 = s; bus.req0 = 1'b1;
      end
      push(idx, a, b, s);
   endtask

   task automatic wait_ack(input int budget, output int n);
      sb_t  e;
      logic hit;
      logic [1:0] exp_ack;
      hit = 1'b0;
      n = 0;
      while (!hit && n < budget) begin
         @(negedge clock);
         n++;
         hit = bus.ack0 | bus.ack1;
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL ack_timeout: none in %0d cycles", budget);
      end else if (q.size() == 0) begin
         bad++;
         $display("FAIL ack_extra: ack with empty scoreboard");
      end else begin
         e = q.pop_front();
         exp_ack = e.idx ? 2'b10 : 2'b01;
         if ({bus.ack1, bus.ack0} !== exp_ack) begin
            bad++;
            $display("FAIL ack_who: got %b want %b",
                     {bus.ack1, bus.ack0}, exp_ack);
         end
         total++;
         if (bus.result !== e.res) begin
            bad++;
            $display("FAIL result: got %h want %h",
                     bus.result, e.res);
         end
         total++;
         if (bus.ovf !== e.ovf) begin
            bad++;
            $display("FAIL ovf: got %b want %b", bus.ovf, e.ovf);
         end
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      q.delete();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      logic [69:0] got;
      got = {bus.ack0, bus.ack1, bus.busy, bus.ovf,
             bus.add_cin, bus.result, bus.add_a[31:0] ^ 32'h0,
             1'b0};
      total++;
      if (got !== '0 || bus.add_b !== '0) begin
         bad++;
         $display("FAIL %s: got %h/%h want 0", tag, got, bus.add_b);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      check_zero("reset_state");
`ifdef ADD_ARBITER_OVF_CNT_EN
      total++;
      if (bus.ovf_cnt !== 8'd0) begin
         bad++;
         $display("FAIL reset_cnt: got %0d want 0", bus.ovf_cnt);
      end
`endif
   endtask

   task automatic test_single();
      int n;
      drive(1'b0, 32'd5, 32'd7, 1'b0);
      wait_ack(6, n);
      bus.req0 = 1'b0;
      total++;
      if (n !== 2) begin
         bad++;
         $display("FAIL single_lat: got %0d want 2", n);
      end
      @(negedge clock);
      total++;
      if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000) begin
         bad++;
         $display("FAIL single_pulse: got %b want 000",
                  {bus.ack0, bus.ack1, bus.busy});
      end
   endtask

   task automatic test_sub();
      int n;
      drive(1'b1, 32'd3, 32'd10, 1'b1);
      @(negedge clock);
      total++;
      if ({bus.busy, bus.add_cin, bus.add_b, bus.add_a}
          !== {1'b1, 1'b1, 32'hFFFF_FFF5, 32'd3}) begin
         bad++;
         $display("FAIL sub_issue: got %b %b %h %h want 1 1 fffffff5 3",
                  bus.busy, bus.add_cin, bus.add_b, bus.add_a);
      end
      wait_ack(6, n);
      bus.req1 = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_ovf();
      int n;
      drive(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0);
      wait_ack(6, n);
      bus.req0 = 1'b0;
      repeat (3) @(negedge clock);
      total++;
      if ({bus.result, bus.ovf} !== {32'h8000_0000, 1'b1}) begin
         bad++;
         $display("FAIL ovf_hold: got %h %b want 80000000 1",
                  bus.result, bus.ovf);
      end
      total++;
      if ({bus.add_a, bus.add_b, bus.add_cin}
          !== {32'h7FFF_FFFF, 32'd1, 1'b0}) begin
         bad++;
         $display("FAIL opnd_hold: got %h %h %b",
                  bus.add_a, bus.add_b, bus.add_cin);
      end
`ifdef ADD_ARBITER_OVF_CNT_EN
      total++;
      if (bus.ovf_cnt !== 8'd1) begin
         bad++;
         $display("FAIL ovf_cnt1: got %0d want 1", bus.ovf_cnt);
      end
`endif
   endtask

   task automatic test_stable();
      int n;
      drive(1'b0, 32'd100, 32'd23, 1'b0);
      @(negedge clock);
      bus.a0 = 32'd5;
      bus.b0 = 32'd5;
      bus.sub0 = 1'b1;
      wait_ack(6, n);
      bus.req0 = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_contention();
      int n;
      do_reset();
      bus.a0 = 32'd10; bus.b0 = 32'd20; bus.sub0 = 1'b0;
      bus.a1 = 32'd100; bus.b1 = 32'd1; bus.sub1 = 1'b1;
      push(1'b0, 32'd10, 32'd20, 1'b0);
      push(1'b1, 32'd100, 32'd1, 1'b1);
      push(1'b0, 32'h8000_0000, 32'd1, 1'b1);
      push(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      wait_ack(8, n);
      bus.a0 = 32'h8000_0000; bus.b0 = 32'd1; bus.sub0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_ack(8, n);
         if (i == 0) begin
            bus.a1 = 32'hFFFF_FFFF; bus.b1 = 32'd2;
            bus.sub1 = 1'b0;
         end
         total++;
         if (n !== 3) begin
            bad++;
            $display("FAIL rr_space%0d: got %0d want 3", i, n);
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_abort();
      int n;
      drive(1'b0, 32'd1, 32'd2, 1'b0);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_zero("abort_zero");
      q.delete();
      bus.req0 = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         total++;
         if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000) begin
            bad++;
            $display("FAIL abort_quiet: got %b want 000",
                     {bus.ack0, bus.ack1, bus.busy});
         end
      end
      drive(1'b0, 32'd40, 32'd2, 1'b0);
      drive(1'b1, 32'd40, 32'd2, 1'b1);
      wait_ack(6, n);
      bus.req0 = 1'b0;
      wait_ack(6, n);
      bus.req1 = 1'b0;
      @(negedge clock);
   endtask

`ifdef ADD_ARBITER_OVF_CNT_EN
   task automatic test_saturate();
      int n;
      for (int i = 0; i < 300; i++)
         drive(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      for (int i = 0; i < 300; i++) begin
         wait_ack(6, n);
         if (i == 299)
            bus.req0 = 1'b0;
      end
      repeat (2) @(negedge clock);
      total++;
      if (bus.ovf_cnt !== 8'd255) begin
         bad++;
         $display("FAIL ovf_sat: got %0d want 255", bus.ovf_cnt);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      reset_n = 1'b0;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.a0 = '0; bus.b0 = '0; bus.sub0 = 1'b0;
      bus.a1 = '0; bus.b1 = '0; bus.sub1 = 1'b0;
      test_reset();
      test_single();
      test_sub();
      test_ovf();
      test_stable();
      test_contention();
      test_abort();
`ifdef ADD_ARBITER_OVF_CNT_EN
      test_saturate();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
